// File: rtl/glyph_row_fetch_arbiter.sv
// glyph_row_fetch_arbiter: two-port round-robin front end for the
// combinational glyph ROM; fetches one 8-pixel glyph row per grant.
module glyph_row_fetch_arbiter #(
  parameter int ROW_W = 8,
  parameter int ROWS  = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic [4:0] c0,
  input  logic [3:0] y0,
  input  logic       req1,
  input  logic [4:0] c1,
  input  logic [3:0] y1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] row_data,
  output logic       busy,
  output logic [4:0] rom_c,
  output logic [3:0] rom_y,
  output logic [2:0] rom_x,
  input  logic       rom_pixel
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [2:0] X_LAST = 3'(ROW_W - 1);
  localparam logic [4:0] ROWS_L = 5'(ROWS);

  logic [1:0] state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_q, last_d;
  logic [4:0] rom_c_q, rom_c_d;
  logic [3:0] rom_y_q, rom_y_d;
  logic [2:0] rom_x_q, rom_x_d;
  logic [7:0] rowbuf_q, rowbuf_d;
  logic [7:0] row_q, row_d;

  logic grant;
  logic gsel;
  logic row_ok;
  logic pix;

  // Pick a port: a lone requester wins, a tie goes to the port not served last.
  always_comb begin
    grant = req0 | req1;
    gsel  = 1'b0;
    if (req0 && req1) begin
      gsel = ~last_q;
    end else if (req1) begin
      gsel = 1'b1;
    end
  end

  // Rows past the glyph height read as blank, without changing fetch timing.
  always_comb begin
    row_ok = ({1'b0, rom_y_q} < ROWS_L);
    pix    = rom_pixel & row_ok;
  end

  // Sequencer: IDLE arbitrates, FETCH walks x=0..7, DONE publishes the row.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    rom_c_d  = rom_c_q;
    rom_y_d  = rom_y_q;
    rom_x_d  = rom_x_q;
    rowbuf_d = rowbuf_q;
    row_d    = row_q;
    case (state_q)
      S_IDLE: begin
        if (grant) begin
          state_d  = S_FETCH;
          owner_d  = gsel;
          rom_c_d  = gsel ? c1 : c0;
          rom_y_d  = gsel ? y1 : y0;
          rom_x_d  = 3'd0;
          rowbuf_d = 8'd0;
        end
      end
      S_FETCH: begin
        rowbuf_d[rom_x_q] = pix;
        rom_x_d = rom_x_q + 3'd1;
        if (rom_x_q == X_LAST) begin
          state_d = S_DONE;
          rom_x_d = 3'd0;
          row_d   = rowbuf_d;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        last_d  = owner_q;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      rom_c_q  <= 5'd0;
      rom_y_q  <= 4'd0;
      rom_x_q  <= 3'd0;
      rowbuf_q <= 8'd0;
      row_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      rom_c_q  <= rom_c_d;
      rom_y_q  <= rom_y_d;
      rom_x_q  <= rom_x_d;
      rowbuf_q <= rowbuf_d;
      row_q    <= row_d;
    end
  end

  // Outputs decoded straight from registered state.
  always_comb begin
    busy     = (state_q != S_IDLE);
    done0    = (state_q == S_DONE) & ~owner_q;
    done1    = (state_q == S_DONE) & owner_q;
    row_data = row_q;
    rom_c    = rom_c_q;
    rom_y    = rom_y_q;
    rom_x    = rom_x_q;
  end

endmodule

// File: tb/tb_glyph_row_fetch_arbiter.sv
// tb_glyph_row_fetch_arbiter: directed bench with a small glyph ROM
// model and hand-computed expected rows.
module tb_glyph_row_fetch_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0 = 1'b0;
  logic [4:0] c0 = 5'd0;
  logic [3:0] y0 = 4'd0;
  logic       req1 = 1'b0;
  logic [4:0] c1 = 5'd0;
  logic [3:0] y1 = 4'd0;
  logic       done0, done1, busy;
  logic [7:0] row_data;
  logic [4:0] rom_c;
  logic [3:0] rom_y;
  logic [2:0] rom_x;
  logic       rom_pixel;
  logic [7:0] rom_word;

  int n_chk = 0;
  int n_fail = 0;

  glyph_row_fetch_arbiter #(.ROW_W(8), .ROWS(12)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .c0(c0), .y0(y0),
    .req1(req1), .c1(c1), .y1(y1),
    .done0(done0), .done1(done1),
    .row_data(row_data), .busy(busy),
    .rom_c(rom_c), .rom_y(rom_y), .rom_x(rom_x),
    .rom_pixel(rom_pixel)
  );

  always #5 clk = ~clk;

  // Glyph ROM stand-in; rows >= 12 are deliberately nonzero.
  function automatic logic [7:0] rom_row(input logic [4:0] c, input logic [3:0] y);
    if (y >= 4'd12) return 8'hA5;
    case ({c, y})
      {5'd27, 4'd1}:  return 8'b00110000;
      {5'd0,  4'd1}:  return 8'b11011000;
      {5'd26, 4'd6}:  return 8'b11010110;
      {5'd28, 4'd11}: return 8'b11111110;
      default:        return {c[2:0], y, c[4]} ^ 8'h3C;
    endcase
  endfunction

  always_comb begin
    rom_word  = rom_row(rom_c, rom_y);
    rom_pixel = rom_word[rom_x];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if ({busy, done0, done1} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ctl: busy/done0/done1=%b want 000", {busy, done0, done1});
    end
    n_chk++;
    if (row_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_row: got %h want 00", row_data);
    end
    n_chk++;
    if ({rom_c, rom_y, rom_x} !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_rom: c=%0d y=%0d x=%0d want 0", rom_c, rom_y, rom_x);
    end
  endtask

  // One request on a port; checks latency, pulse, row and the idle port.
  task automatic fetch(input int port, input logic [4:0] c, input logic [3:0] y,
                       input logic [7:0] exp, input string nm);
    int n;
    bit seen;
    bit other;
    n = 0;
    seen = 0;
    other = 0;
    if (port == 0) begin
      c0 = c; y0 = y; req0 = 1'b1;
    end else begin
      c1 = c; y1 = y; req1 = 1'b1;
    end
    while (!seen && n < 30) begin
      tick();
      n++;
      if (n == 1) begin
        n_chk++;
        if (busy !== 1'b1 || rom_x !== 3'd0) begin
          n_fail++;
          $display("FAIL %s_start: busy=%b x=%0d want 1/0", nm, busy, rom_x);
        end
      end
      if ((port == 0 ? done1 : done0) === 1'b1) other = 1;
      seen = (port == 0) ? (done0 === 1'b1) : (done1 === 1'b1);
    end
    n_chk++;
    if (!seen || n != 9) begin
      n_fail++;
      $display("FAIL %s_lat: done after %0d cycles seen=%0d want 9", nm, n, seen);
    end
    n_chk++;
    if (row_data !== exp) begin
      n_fail++;
      $display("FAIL %s_row: got %b want %b", nm, row_data, exp);
    end
    n_chk++;
    if (other) begin
      n_fail++;
      $display("FAIL %s_other: other port done pulsed, want none", nm);
    end
    tick();
    req0 = 1'b0;
    req1 = 1'b0;
    n_chk++;
    if ({done0, done1, busy} !== 3'b000 || row_data !== exp) begin
      n_fail++;
      $display("FAIL %s_after: d0/d1/busy=%b row=%b want 000/%b",
               nm, {done0, done1, busy}, row_data, exp);
    end
  endtask

  task automatic test_single();
    fetch(0, 5'd27, 4'd1, 8'b00110000, "p0_g27");
    fetch(1, 5'd0, 4'd1, 8'b11011000, "p1_g0");
    fetch(1, 5'd26, 4'd6, 8'b11010110, "p1_g26");
    fetch(1, 5'd28, 4'd11, 8'b11111110, "p1_g28");
  endtask

  task automatic test_back_to_back();
    int ev_port[6];
    int ev_t[6];
    int ne;
    int t;
    do_reset();
    c0 = 5'd27; y0 = 4'd1;
    c1 = 5'd26; y1 = 4'd6;
    req0 = 1'b1;
    req1 = 1'b1;
    ne = 0;
    t = 0;
    while (ne < 6 && t < 90) begin
      tick();
      t++;
      if (done0 === 1'b1 || done1 === 1'b1) begin
        ev_port[ne] = (done1 === 1'b1) ? 1 : 0;
        ev_t[ne] = t;
        n_chk++;
        if (row_data !== (done1 ? 8'b11010110 : 8'b00110000)) begin
          n_fail++;
          $display("FAIL rr_row%0d: got %b on port %0d", ne, row_data, ev_port[ne]);
        end
        ne++;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    n_chk++;
    if (ne != 6) begin
      n_fail++;
      $display("FAIL rr_count: got %0d dones want 6", ne);
    end
    for (int i = 0; i < ne; i++) begin
      n_chk++;
      if (ev_port[i] != (i % 2) || ev_t[i] != 9 + 10 * i) begin
        n_fail++;
        $display("FAIL rr_ev%0d: port %0d at %0d want port %0d at %0d",
                 i, ev_port[i], ev_t[i], i % 2, 9 + 10 * i);
      end
    end
    tick();
    tick();
  endtask

  task automatic test_out_of_range();
    int bad;
    bad = 0;
    c0 = 5'd31; y0 = 4'd12; req0 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (rom_x !== 3'(k - 1) || busy !== 1'b1) bad++;
    end
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL oor_steps: %0d bad x steps, last x=%0d want 7", bad, rom_x);
    end
    tick();
    n_chk++;
    if (done0 !== 1'b1 || row_data !== 8'h00) begin
      n_fail++;
      $display("FAIL oor_row: done0=%b row=%h want 1/00", done0, row_data);
    end
    tick();
    req0 = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_fetch();
    bit pulsed;
    pulsed = 0;
    c1 = 5'd0; y1 = 4'd1; req1 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (done0 === 1'b1 || done1 === 1'b1) pulsed = 1;
    end
    n_chk++;
    if (rom_x !== 3'd4) begin
      n_fail++;
      $display("FAIL mid_x: got %0d want 4", rom_x);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    if (done0 === 1'b1 || done1 === 1'b1) pulsed = 1;
    n_chk++;
    if (busy !== 1'b0 || row_data !== 8'h00 || rom_x !== 3'd0 || pulsed) begin
      n_fail++;
      $display("FAIL mid_rst: busy=%b row=%h x=%0d pulsed=%0d want 0/00/0/0",
               busy, row_data, rom_x, pulsed);
    end
    fetch(1, 5'd0, 4'd1, 8'b11011000, "mid_reserve");
  endtask

  task automatic test_hold_inputs();
    int bad;
    bad = 0;
    c0 = 5'd27; y0 = 4'd1; req0 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 3) begin
        c0 = 5'd0;
        y0 = 4'd6;
      end
      if (rom_c !== 5'd27 || rom_y !== 4'd1) bad++;
    end
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL hold_addr: %0d cycles rom_c/y moved, now %0d/%0d want 27/1",
               bad, rom_c, rom_y);
    end
    tick();
    n_chk++;
    if (done0 !== 1'b1 || row_data !== 8'b00110000) begin
      n_fail++;
      $display("FAIL hold_row: done0=%b row=%b want 1/00110000", done0, row_data);
    end
    tick();
    req0 = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid_fetch();
    test_hold_inputs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/glyph_row_fetch_arbiter.md
Name: glyph_row_fetch_arbiter

Overview:
- Shares the single combinational glyph ROM port (glyph 5b, row 4b, column 3b → 1 pixel) between two requesters: the rain-column generator (port 0) and the status overlay (port 1).
- Each accepted request is sequenced into 8 ROM column lookups (x=0..7). The result is returned as one 8-bit glyph row with a done pulse.
- Sits between the requesters and the glyph ROM instance; drives the ROM address, samples the ROM pixel.

Parameters:
- ROW_W, 8, pixels per glyph row; also the FETCH length in cycles.
- ROWS, 12, valid glyph rows (0..ROWS-1); higher row indices return zero.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- req0  input  1  port-0 request (level)
- c0  input  5  port-0 glyph index
- y0  input  4  port-0 glyph row
- req1  input  1  port-1 request (level)
- c1  input  5  port-1 glyph index
- y1  input  4  port-1 glyph row
- done0  output  1  one-cycle pulse: row_data valid for port 0
- done1  output  1  one-cycle pulse: row_data valid for port 1
- row_data  output  8  fetched row; bit i = ROM pixel at x=i
- busy  output  1  high in FETCH and DONE
- rom_c  output  5  ROM glyph index
- rom_y  output  4  ROM row
- rom_x  output  3  ROM column
- rom_pixel  input  1  ROM pixel (combinational from rom_c/rom_y/rom_x)

Behaviour:
- Clock and reset: one clock domain, clk. Reset is synchronous, active-high, applied on a clk edge.
- Reset values:
  - state=IDLE; done0=done1=0; busy=0; row_data=0.
  - rom_c=0, rom_y=0, rom_x=0.
  - last_served=1, so port 0 wins the first tie.
- States: IDLE → FETCH → DONE → IDLE.
- IDLE:
  - If neither req is high, stay in IDLE.
  - If exactly one req is high, grant that port.
  - If both are high, grant the port ≠ last_served.
  - On grant: latch the port's c/y into rom_c/rom_y, record owner, set rom_x=0, clear the row shift register, go to FETCH.
- FETCH (exactly ROW_W=8 cycles):
  - Each cycle: rowbuf[rom_x] <= rom_pixel, then rom_x increments.
  - After the cycle with rom_x=7 is captured, rom_x wraps to 0 and state goes to DONE.
  - rom_c/rom_y are held stable for the whole FETCH.
- Out-of-range row: if the latched row ≥ ROWS, all captured bits are forced to 0. FETCH still takes 8 cycles, so timing is data-independent.
- DONE (1 cycle):
  - row_data = rowbuf (registered; it holds its value until the next DONE).
  - done<owner>=1 for this cycle only; last_served=owner.
  - Next state is IDLE.
- Latency: request seen in IDLE at cycle T → done at T+9. Transaction period is 10 cycles.
- Request handshake:
  - A requester holds req, c and y stable until it sees its done.
  - It deasserts req in the cycle after done (the IDLE cycle).
  - If req is still high in that IDLE cycle, it is treated as a new request.
- Changes during a transaction: c/y changes outside IDLE are ignored, because they were latched at grant.
- Starvation: under continuous requests from both ports, service strictly alternates 0,1,0,1…
- Unused input: a req asserted while busy waits; it is never dropped.
- Reset mid-FETCH or mid-DONE: abort immediately to reset values; no done is emitted. A req still high after reset is re-arbitrated, with port 0 favoured.
- busy=1 in FETCH and DONE, 0 in IDLE.

Test Plan:
- Reset, then req0 with c0=27, y0=1 held: FETCH starts next cycle; done0 pulses exactly 9 cycles after the first req0-high IDLE cycle; row_data=8'b00110000; done1 stays 0.
- req1 with c1=0, y1=1: row_data=8'b11011000 with done1. Then c1=26, y1=6: row_data=8'b11010110. Then c1=28, y1=11: row_data=8'b11111110.
- req0 and req1 raised in the same cycle after reset: port 0 is served first, port 1 next. With both held continuously for 6 transactions, the done order is 0,1,0,1,0,1 and each period is 10 cycles.
- req0 with y0=12 (c0=31) → row_data=8'h00 after the full 9-cycle latency; rom_x still steps 0..7.
- Assert reset during FETCH (rom_x=4): next cycle state=IDLE, busy=0, row_data=0, no done pulse. With req1 held, port 1 is re-served and returns the correct row.
- Change c0 from 27 to 0 mid-FETCH: row_data still equals the glyph 27 row; rom_c stays stable throughout FETCH.
